// File: rtl/serial_adder_ctrl_if.sv
// Host-side bundle for serial_adder_ctrl: start/ready/done handshake, operands and result.
// SERIAL_ADDER_OVERFLOW_EN adds the ovf result bit.
interface serial_adder_ctrl_if #(
    parameter int N = 8
);
    // Handshake: the block accepts a request on any rising edge where start=1 and ready=1.
    // The operands and cin are sampled on that same edge. done pulses for one cycle when sum/cout are new.
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: a single full-adder cell is reused LSB first, one bit per clock.
// SERIAL_ADDER_OVERFLOW_EN adds a registered two's-complement overflow flag.
module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_adder_ctrl_if.slave    bus,
    output logic [1:0]            o_dbg_state
);
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_a_sr;
    logic [N-1:0]  r_b_sr;
    logic [N-1:0]  r_acc;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sum;
    logic          r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic          r_ovf;
`endif

    logic w_bit_s;
    logic w_bit_c;

    // The shared full-adder cell.
    assign w_bit_s = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_bit_c = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                // DONE accepts a new request just like IDLE, giving back-to-back operation.
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.b;
                        r_carry <= bus.cin;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sr  <= {1'b0, r_a_sr[N-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[N-1:1]};
                    r_acc   <= {w_bit_s, r_acc[N-1:1]};
                    r_carry <= w_bit_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Last bit: publish the result including this cycle's sum bit.
                        r_sum   <= {w_bit_s, r_acc[N-1:1]};
                        r_cout  <= w_bit_c;
`ifdef SERIAL_ADDER_OVERFLOW_EN
                        r_ovf   <= r_carry ^ w_bit_c;
`endif
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready   = (r_state != RUN);
    assign bus.busy    = (r_state == RUN);
    assign bus.done    = (r_state == DONE);
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    assign bus.ovf     = r_ovf;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed corner cases plus random operands.
module tb_serial_adder_ctrl;
  localparam int N = 8;
  localparam int W = N + 2;  // {ovf, cout, sum}

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  serial_adder_ctrl_if #(.N(N)) bus();

  serial_adder_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  logic [N:0]   held = '0;
  logic         held_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    int unsigned u;
    int          s;
    logic        o;
    u = int'(a) + int'(b) + int'(cin);
    s = int'($signed(a)) + int'($signed(b)) + int'(cin);
    o = (s > (2 ** (N - 1)) - 1) || (s < -(2 ** (N - 1)));
    return {o, u[N:0]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      held     = '0;
      held_ovf = 1'b0;
    end else begin
      check("ready_xor_busy", 64'(bus.ready ^ bus.busy), 64'd1);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_without_request: got done=1 expected done=0 (t=%0t)", $time);
        end else begin
          logic [W-1:0] e;
          int           acc;
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("sum", 64'(bus.sum), 64'(e[N-1:0]));
          check("cout", 64'(bus.cout), 64'(e[N]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
          check("ovf", 64'(bus.ovf), 64'(e[N+1]));
`endif
          check("latency", 64'(cyc - acc), 64'(N));
          held     = e[N:0];
          held_ovf = e[N+1];
        end
      end else begin
        check("result_hold", 64'({bus.cout, bus.sum}), 64'(held));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("ovf_hold", 64'(bus.ovf), 64'(held_ovf));
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                       output logic in_done);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    in_done = bus.done;
    if (!bus.ready) begin
      check("ready_timeout", 64'(bus.ready), 64'd1);
    end else begin
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      bus.start = 1'b1;
      exp_q.push_back(model(a, b, cin));
      acc_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = N'($urandom);
      bus.b     = N'($urandom);
      bus.cin   = 1'($urandom);
    end
  endtask

  task automatic add(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
    logic d;
    issue(a, b, cin, d);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("completion_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(bus.ready), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_sum"}, 64'(bus.sum), 64'd0);
    check({tag, "_cout"}, 64'(bus.cout), 64'd0);
    check({tag, "_state_idle"}, 64'(dbg_state), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic in_done;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset, then idle with no spurious done.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");
    repeat (20) @(negedge clk);

    // Basic add and carry chains.
    add(8'd100, 8'd27, 1'b0);
    wait_idle();
    add(8'h5A, 8'hA5, 1'b1);
    wait_idle();
    add(8'hFF, 8'h01, 1'b0);
    wait_idle();

    // Signed overflow cases.
    add(8'h7F, 8'h01, 1'b0);
    wait_idle();
    add(8'h80, 8'h80, 1'b0);
    wait_idle();

    // start while busy is ignored.
    add(8'd3, 8'd4, 1'b0);
    repeat (3) @(negedge clk);
    check("busy_mid_run", 64'(bus.busy), 64'd1);
    bus.a     = 8'd200;
    bus.b     = 8'd200;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Back-to-back: the second request lands in the DONE cycle.
    add(8'd5, 8'd6, 1'b0);
    issue(8'd1, 8'd1, 1'b0, in_done);
    check("back_to_back_in_done", 64'(in_done), 64'd1);
    wait_idle();

    // Reset mid-operation abandons the add.
    add(8'hF0, 8'h0F, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) @(negedge clk);
    add(8'd1, 8'd2, 1'b0);
    wait_idle();

    // Random operands with random gaps (gap 0 exercises back-to-back).
    for (int i = 0; i < 40; i++) begin
      add(N'($urandom), N'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Sequencer that time-shares one adder_1 full-adder cell to add two N-bit operands bit-serially, LSB first, one bit per clock. The block owns operand shift registers, a carry flip-flop, a bit counter and a 3-state FSM. It sits beside the ripple adders as a low-area alternative and exposes a start/ready/done handshake to the host logic.

Parameters:
N, 8, operand/result width in bits; legal range 2 to 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  request a new addition; sampled only when ready=1
a  input  N  operand A; captured on the accepting edge
b  input  N  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
ready  output  1  block can accept start this cycle
busy  output  1  addition in progress
done  output  1  one-cycle pulse: sum and cout are valid and newly updated
sum  output  N  registered result; holds until the next completion
cout  output  1  registered carry-out of the MSB

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; ready=1, busy=0, done=0, sum=0, cout=0; shift registers, carry flip-flop and counter cleared.
- The adder_1 instance is combinational: inputs a_sr[0], b_sr[0] and the carry flip-flop; outputs bit_s and bit_c.
- States:
  - IDLE: ready=1, busy=0. On start=1 at an edge: a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, go to RUN.
  - RUN: ready=0, busy=1. Each edge: a_sr and b_sr shift right by 1; acc shifts right with bit_s entering the MSB; carry<=bit_c; cnt<=cnt+1.
  - At the edge where cnt=N-1: sum<=acc with the final shift applied, cout<=bit_c, go to DONE.
  - DONE: done=1, ready=1, busy=0 for exactly one cycle. start=1 here is accepted exactly as in IDLE, with RUN next (back-to-back). Otherwise go to IDLE.
- Latency: a start accepted at edge 0 runs RUN edges 1..N, and done is high during the cycle after edge N. Throughput is one addition per N+1 cycles.
- Width and arithmetic: the counter is $clog2(N) bits wide. {cout,sum} equals a+b+cin, taken modulo 2^(N+1).
- start is ignored while busy=1. Operand changes during RUN have no effect.
- sum and cout change only at the completing edge, or on reset.
- done never asserts without a preceding accepted start.
- If rst_n falls mid-RUN, the operation is abandoned immediately, all outputs take their reset values, and no done pulse is produced.
- Exactly one of the following holds every cycle: ready=1, or busy=1.

Optional Feature:
SERIAL_ADDER_OVERFLOW_EN
- Defined: adds output port ovf (1 bit), the two's-complement signed overflow of the operation.
  - ovf = carry into MSB XOR carry out of MSB, i.e. the carry flip-flop value at the final RUN edge XOR bit_c.
  - Registered alongside sum and cout, valid with done, held until the next completion, reset to 0.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle, N=8: hold rst_n=0 for 2 cycles, then release -> ready=1, busy=0, done=0, sum=8'h00, cout=0; no done pulse within 20 idle cycles.
2. Basic add: a=100, b=27, cin=0, start pulsed -> busy for 8 cycles, done on the 9th cycle after the start edge, sum=127, cout=0; with OVERFLOW_EN, ovf=0.
3. Carry chain and cin: a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
4. Signed overflow (OVERFLOW_EN defined): a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
5. Busy protection and back-to-back:
   - Pulse start with a=3, b=4; re-pulse start with a=200, b=200 mid-RUN -> the second request is ignored and the result is sum=7.
   - Hold start high through DONE with a=1, b=1 -> the next operation begins with no IDLE cycle; second done gives sum=2.
6. Reset mid-operation: start a=8'hF0, b=8'h0F; assert rst_n=0 after 4 RUN cycles -> outputs cleared immediately and no done pulse. After release, a=1, b=2 -> sum=3.
